// File: rtl/pipe_alu.sv
// pipe_alu: single-issue ALU followed by a delay pipeline.
// The result is computed combinationally from the inputs. It is captured in
// stage 1 and then travels through LATENCY-1 delay stages. Each stage has its
// own valid bit. A stage's data registers only load behind a valid bit, so
// during bubbles the outputs keep showing the last real result.
module pipe_alu #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter bit SAT     = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             valid_i,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             valid_o,
    output logic [WIDTH-1:0] out,
    output logic             flag,
    output logic             err
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_ASR  = 4'd8,
        OP_GT   = 4'd9,
        OP_EQ   = 4'd10,
        OP_LT   = 4'd11,
        OP_GTE  = 4'd12,
        OP_LTE  = 4'd13,
        OP_MUL  = 4'd14,
        OP_RSVD = 4'd15
    } op_e;

    // WIDTH always fits in WIDTH bits for WIDTH >= 2. This lets the shift
    // range test compare against the full right operand.
    localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

    op_e                  op_sel;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     diff;
    logic [2*WIDTH-1:0]   product;
    logic                 less;
    logic                 equal;
    logic                 shift_big;

    logic [WIDTH-1:0]     res_out;
    logic                 res_flag;
    logic                 res_err;

    assign op_sel    = op_e'(op);
    assign sum       = {1'b0, left} + {1'b0, right};
    assign diff      = left - right;
    assign product   = {{WIDTH{1'b0}}, left} * {{WIDTH{1'b0}}, right};
    assign less      = left < right;
    assign equal     = left == right;
    assign shift_big = right >= WIDTH_VAL;

    // Stage-1 result logic: decode op and form out/flag/err.
    always_comb begin
        // NOTE: every output of this block gets a default first. Then no
        // path through the case statement can leave a value unassigned,
        // and no latch is inferred.
        res_out  = '0;
        res_flag = 1'b0;
        res_err  = 1'b0;
        case (op_sel)
            OP_ADD: begin
                res_flag = sum[WIDTH];
                res_out  = (SAT && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
            end
            OP_SUB: begin
                res_flag = less;
                res_out  = (SAT && less) ? '0 : diff;
            end
            OP_AND: res_out = left & right;
            OP_OR:  res_out = left | right;
            OP_XOR: res_out = left ^ right;
            OP_NOT: res_out = ~left;
            OP_SHL: res_out = shift_big ? '0 : (left << right);
            OP_SHR: res_out = shift_big ? '0 : (left >> right);
            OP_ASR: res_out = shift_big ? {WIDTH{left[WIDTH-1]}}
                                        : WIDTH'($signed(left) >>> right);
            OP_GT: begin
                res_flag = !less && !equal;
                res_out  = {{(WIDTH-1){1'b0}}, res_flag};
            end
            OP_EQ: begin
                res_flag = equal;
                res_out  = {{(WIDTH-1){1'b0}}, res_flag};
            end
            OP_LT: begin
                res_flag = less;
                res_out  = {{(WIDTH-1){1'b0}}, res_flag};
            end
            OP_GTE: begin
                res_flag = !less;
                res_out  = {{(WIDTH-1){1'b0}}, res_flag};
            end
            OP_LTE: begin
                res_flag = less || equal;
                res_out  = {{(WIDTH-1){1'b0}}, res_flag};
            end
            OP_MUL: begin
                res_flag = |product[2*WIDTH-1:WIDTH];
                res_out  = product[WIDTH-1:0];
            end
            OP_RSVD: res_err = 1'b1;
            default: res_err = 1'b1;
        endcase
    end

    // Stage registers: index 0 is the computing stage; the rest are delays.
    logic [WIDTH-1:0]   st_out [LATENCY];
    logic [LATENCY-1:0] st_flag;
    logic [LATENCY-1:0] st_err;
    logic [LATENCY-1:0] st_valid;

    // Pipeline advance. Reset wins over en. en=0 freezes every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data registers are cleared here along with the valid
            // bits. The outputs must read 0 right after reset, and these are
            // a handful of flops rather than a RAM, so clearing them is cheap.
            st_valid <= '0;
            st_flag  <= '0;
            st_err   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                st_out[i] <= '0;
            end
        end else if (en) begin
            // NOTE: non-blocking assignments here. Each stage reads the
            // previous stage's value from before the edge, so the stages
            // shift by exactly one position per edge.
            st_valid[0] <= valid_i;
            if (valid_i) begin
                st_out[0]  <= res_out;
                st_flag[0] <= res_flag;
                st_err[0]  <= res_err;
            end
            for (int i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                if (st_valid[i-1]) begin
                    st_out[i]  <= st_out[i-1];
                    st_flag[i] <= st_flag[i-1];
                    st_err[i]  <= st_err[i-1];
                end
            end
        end
    end

    assign valid_o = st_valid[LATENCY-1];
    assign out     = st_out[LATENCY-1];
    assign flag    = st_flag[LATENCY-1];
    assign err     = st_err[LATENCY-1];

endmodule

// File: tb/tb_pipe_alu.sv
// Testbench for pipe_alu. Two instances (SAT=0 and SAT=1) share the same
// inputs. WIDTH=8 and LATENCY=3. A timestamp-based reference model checks
// every cycle, and directed tables and sequences cover the corner cases.
module tb_pipe_alu;

    localparam int W   = 8;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         valid_i;
    logic [3:0]   op;
    logic [W-1:0] left;
    logic [W-1:0] right;

    logic         v0, f0, e0;
    logic [W-1:0] o0;
    logic         v1, f1, e1;
    logic [W-1:0] o1;

    always #5 clk = ~clk;

    pipe_alu #(.WIDTH(W), .LATENCY(LAT), .SAT(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .valid_i(valid_i), .op(op),
        .left(left), .right(right),
        .valid_o(v0), .out(o0), .flag(f0), .err(e0)
    );

    pipe_alu #(.WIDTH(W), .LATENCY(LAT), .SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .valid_i(valid_i), .op(op),
        .left(left), .right(right),
        .valid_o(v1), .out(o1), .flag(f1), .err(e1)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int out;
        bit flag;
        bit err;
    } res_t;

    typedef struct {
        int   tag;
        res_t r0;
        res_t r1;
    } item_t;

    // Plain integer arithmetic over the 8-bit operands.
    function automatic res_t ref_alu(input int o, input int l, input int r, input bit sat);
        res_t res;
        int   s;
        res = '{out: 0, flag: 1'b0, err: 1'b0};
        case (o)
            0: begin
                s = l + r;
                res.flag = (s > 255);
                res.out  = (sat && res.flag) ? 255 : s % 256;
            end
            1: begin
                res.flag = (l < r);
                res.out  = (sat && res.flag) ? 0 : (l - r + 256) % 256;
            end
            2: res.out = l & r;
            3: res.out = l | r;
            4: res.out = l ^ r;
            5: res.out = 255 - l;
            6: res.out = (r >= W) ? 0 : (l * (1 << r)) % 256;
            7: res.out = (r >= W) ? 0 : l / (1 << r);
            8: begin
                if (r >= W) res.out = (l >= 128) ? 255 : 0;
                else begin
                    s = (l >= 128) ? l - 256 : l;
                    s = s >>> r;
                    res.out = (s + 256) % 256;
                end
            end
            9:  res.flag = (l > r);
            10: res.flag = (l == r);
            11: res.flag = (l < r);
            12: res.flag = (l >= r);
            13: res.flag = (l <= r);
            14: begin
                s = l * r;
                res.flag = (s > 255);
                res.out  = s % 256;
            end
            default: res.err = 1'b1;
        endcase
        if (o >= 9 && o <= 13) res.out = int'(res.flag);
        return res;
    endfunction

    // The model stores each accepted item with the index of the en-high edge
    // that accepted it. The item is due LAT-1 en-high edges later.
    item_t q[$];
    int    edges     = 0;
    bit    exp_valid = 1'b0;
    res_t  last0     = '{out: 0, flag: 1'b0, err: 1'b0};
    res_t  last1     = '{out: 0, flag: 1'b0, err: 1'b0};

    // One clock cycle: drive inputs, advance the model on the edge, then
    // compare both instances 1 time unit after the edge.
    task automatic step(input bit rst, input bit e, input bit v, input int o,
                        input int l, input int r, input string tag);
        item_t it;
        reset   = rst;
        en      = e;
        valid_i = v;
        op      = 4'(o);
        left    = W'(l);
        right   = W'(r);
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_valid = 1'b0;
            last0 = '{out: 0, flag: 1'b0, err: 1'b0};
            last1 = '{out: 0, flag: 1'b0, err: 1'b0};
        end else if (e) begin
            edges++;
            if (v) begin
                it.tag = edges;
                it.r0  = ref_alu(o, l, r, 1'b0);
                it.r1  = ref_alu(o, l, r, 1'b1);
                q.push_back(it);
            end
            exp_valid = 1'b0;
            if (q.size() > 0 && q[0].tag + LAT - 1 == edges) begin
                last0 = q[0].r0;
                last1 = q[0].r1;
                exp_valid = 1'b1;
                void'(q.pop_front());
            end
        end
        #1;
        check({tag, " valid_o"},     64'(v0), 64'(exp_valid));
        check({tag, " out"},         64'(o0), 64'(last0.out));
        check({tag, " flag"},        64'(f0), 64'(last0.flag));
        check({tag, " err"},         64'(e0), 64'(last0.err));
        check({tag, " sat valid_o"}, 64'(v1), 64'(exp_valid));
        check({tag, " sat out"},     64'(o1), 64'(last1.out));
        check({tag, " sat flag"},    64'(f1), 64'(last1.flag));
        check({tag, " sat err"},     64'(e1), 64'(last1.err));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int op;
        int l;
        int r;
        int e_out;
        bit e_flag;
        bit e_err;
        int e_sat;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    logic [W-1:0] held;

    initial begin
        vecs = '{
            '{0, 200, 100,  44, 1'b1, 1'b0, 255},
            '{1,   5,   7, 254, 1'b1, 1'b0,   0},
            '{0, 100, 155, 255, 1'b0, 1'b0, 255},
            '{0, 100, 156,   0, 1'b1, 1'b0, 255},
            '{1,   7,   5,   2, 1'b0, 1'b0,   2},
            '{2, 'hF0, 'h3C, 'h30, 1'b0, 1'b0, 'h30},
            '{3, 'hF0, 'h3C, 'hFC, 1'b0, 1'b0, 'hFC},
            '{4, 'hF0, 'h3C, 'hCC, 1'b0, 1'b0, 'hCC},
            '{5, 'h0F, 'h55, 'hF0, 1'b0, 1'b0, 'hF0},
            '{6, 'h81,   9, 'h00, 1'b0, 1'b0, 'h00},
            '{6, 'h81,   7, 'h80, 1'b0, 1'b0, 'h80},
            '{6, 'h81, 255, 'h00, 1'b0, 1'b0, 'h00},
            '{7, 'h81,   1, 'h40, 1'b0, 1'b0, 'h40},
            '{7, 'h81,   8, 'h00, 1'b0, 1'b0, 'h00},
            '{8, 'h81,   9, 'hFF, 1'b0, 1'b0, 'hFF},
            '{8, 'h81,   1, 'hC0, 1'b0, 1'b0, 'hC0},
            '{8, 'h81,   7, 'hFF, 1'b0, 1'b0, 'hFF},
            '{8, 'h41,   8, 'h00, 1'b0, 1'b0, 'h00},
            '{11,  3,   9,   1, 1'b1, 1'b0,   1},
            '{10,  4,   4,   1, 1'b1, 1'b0,   1},
            '{9,   3,   9,   0, 1'b0, 1'b0,   0},
            '{12,  9,   9,   1, 1'b1, 1'b0,   1},
            '{13,  9,   3,   0, 1'b0, 1'b0,   0},
            '{13,  3,   3,   1, 1'b1, 1'b0,   1},
            '{14, 16,  16,   0, 1'b1, 1'b0,   0},
            '{14, 15,  17, 255, 1'b0, 1'b0, 255},
            '{15,  3,   4,   0, 1'b0, 1'b1,   0},
            '{9,   9,   3,   1, 1'b1, 1'b0,   1}
        };

        reset = 1'b1; en = 1'b0; valid_i = 1'b0; op = '0; left = '0; right = '0;

        // Reset state: the reset edge with en=0 must still clear everything.
        step(1, 0, 1, 0, 1, 1, "reset");
        step(1, 1, 1, 0, 1, 1, "reset2");
        check("reset valid_o", 64'(v0), 64'd0);
        check("reset out",     64'(o0), 64'd0);

        // Table: issue one op, then wait LAT-1 bubble cycles and compare.
        for (int i = 0; i < NV; i++) begin
            step(0, 1, 1, vecs[i].op, vecs[i].l, vecs[i].r, "vec issue");
            for (int k = 1; k < LAT; k++) step(0, 1, 0, 0, 0, 0, "vec wait");
            check($sformatf("vec%0d valid_o", i), 64'(v0), 64'd1);
            check($sformatf("vec%0d out", i),     64'(o0), 64'(vecs[i].e_out));
            check($sformatf("vec%0d flag", i),    64'(f0), 64'(vecs[i].e_flag));
            check($sformatf("vec%0d err", i),     64'(e0), 64'(vecs[i].e_err));
            check($sformatf("vec%0d sat out", i), 64'(o1), 64'(vecs[i].e_sat));
        end

        // Back-to-back ADD then SUB: results appear on consecutive cycles.
        step(0, 1, 1, 0, 200, 100, "b2b add");
        step(0, 1, 1, 1, 5, 7, "b2b sub");
        step(0, 1, 0, 0, 0, 0, "b2b c2");
        check("b2b c3 valid_o", 64'(v0), 64'd1);
        check("b2b c3 out",     64'(o0), 64'd44);
        check("b2b c3 flag",    64'(f0), 64'd1);
        step(0, 1, 0, 0, 0, 0, "b2b c3");
        check("b2b c4 valid_o", 64'(v0), 64'd1);
        check("b2b c4 out",     64'(o0), 64'd254);
        check("b2b c4 flag",    64'(f0), 64'd1);
        check("b2b c4 sat out", 64'(o1), 64'd0);
        step(0, 1, 0, 0, 0, 0, "b2b c4");
        check("b2b bubble valid_o", 64'(v0), 64'd0);
        check("b2b bubble holds",   64'(o0), 64'd254);

        // Stall mid-flight: MUL 16*16, one advance, then a 4-cycle freeze.
        // valid_i is held high during the freeze and must be ignored.
        step(0, 1, 1, 14, 16, 16, "stall issue");
        step(0, 1, 0, 0, 0, 0, "stall adv");
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 77, 88, "stall frz");
            check("stall frz valid_o", 64'(v0), 64'd0);
        end
        step(0, 1, 0, 0, 0, 0, "stall resume");
        check("stall result valid_o", 64'(v0), 64'd1);
        check("stall result out",     64'(o0), 64'd0);
        check("stall result flag",    64'(f0), 64'd1);
        // Freeze while a result is being shown: it must stay put.
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0, "hold frz");
            check("hold valid_o", 64'(v0), 64'd1);
            check("hold flag",    64'(f0), 64'd1);
        end
        step(0, 1, 0, 0, 0, 0, "hold drain");
        check("hold drain valid_o", 64'(v0), 64'd0);

        // Reset mid-flight: two ops accepted, the third sits on the reset edge.
        step(0, 1, 1, 0, 1, 2, "rmf op1");
        step(0, 1, 1, 4, 'hAA, 'h55, "rmf op2");
        step(1, 1, 1, 15, 3, 3, "rmf reset");
        check("rmf reset out", 64'(o0), 64'd0);
        for (int k = 0; k < LAT + 2; k++) begin
            step(0, 1, 0, 0, 0, 0, "rmf drain");
            check("rmf no valid_o", 64'(v0), 64'd0);
            check("rmf out zero",   64'(o0), 64'd0);
        end

        // Illegal op at normal latency.
        step(0, 1, 1, 15, 200, 100, "ill issue");
        step(0, 1, 0, 0, 0, 0, "ill w1");
        check("ill early valid_o", 64'(v0), 64'd0);
        step(0, 1, 0, 0, 0, 0, "ill w2");
        check("ill valid_o", 64'(v0), 64'd1);
        check("ill err",     64'(e0), 64'd1);
        check("ill out",     64'(o0), 64'd0);

        // Randomized traffic against the model, including stalls and resets.
        for (int n = 0; n < 600; n++) begin
            bit rr, ee, vv;
            int oo, ll, rv;
            rr = ($urandom_range(0, 59) == 0);
            ee = ($urandom_range(0, 4) != 0);
            vv = ($urandom_range(0, 3) != 0);
            oo = $urandom_range(0, 15);
            ll = $urandom_range(0, 255);
            rv = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : $urandom_range(0, 255);
            step(rr, ee, vv, oo, ll, rv, "rand");
        end

        // Final drain with en high so the model queue empties.
        for (int k = 0; k < LAT; k++) step(0, 1, 0, 0, 0, 0, "drain");
        held = o0;
        step(0, 1, 0, 0, 0, 0, "drain idle");
        check("idle valid_o", 64'(v0), 64'd0);
        check("idle holds",   64'(o0), 64'(held));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
